brc_arb: RTL
============

# brc_arb

Two-requester arbiter sharing one `brc` comparator instance between the branch unit (requester 0) and the ALU set-less-than path (requester 1). It performs round-robin arbitration with valid/ready handshakes on both requests and the response, and drives the shared comparator with the granted operands. Each result is registered, tagged with the requester ID, and held until the consumer accepts it. Per-requester saturating grant counters are kept for performance debug.

## Interface
- `FIXED_PRIO`, default 0: 1 = requester 0 always wins; 0 = round-robin.
- `CNT_W`, default 16: width of each grant counter.

- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous and active-low.
- `i_req0_valid` / `i_req1_valid`  in  1  request present.
- `o_req0_ready` / `o_req1_ready`  out  1  request accepted this cycle.
- `i_req0_rs1` / `i_req1_rs1`  in  32  first operand.
- `i_req0_rs2` / `i_req1_rs2`  in  32  second operand.
- `i_req0_signed` / `i_req1_signed`  in  1  1 = signed compare; drives `brc.i_br_un` directly.
- `o_rsp_valid`  out  1  response register full.
- `i_rsp_ready`  in  1  consumer accepts the response.
- `o_rsp_id`  out  1  requester that owns the response.
- `o_rsp_less`  out  1  registered `brc.o_br_less`.
- `o_rsp_equal`  out  1  registered `brc.o_br_equal`.
- `o_gnt_cnt0` / `o_gnt_cnt1`  out  CNT_W  saturating accept counts.

## Operation
- Response register has two states:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `i_rsp_ready` with no new accept.
  - FULL → FULL when it is consumed and refilled in the same cycle.
- `can_take` = EMPTY or `i_rsp_ready`.
- Winner selection:
  - If only one requester is valid, it wins.
  - If both are valid and `FIXED_PRIO`=1, requester 0 wins.
  - Otherwise the requester not equal to `last_gnt` wins.
- `o_reqN_ready` = `can_take` & (winner == N). It is combinational, and at most one ready is high.
- Accept = valid & ready.
- On accept:
  - `brc` inputs are muxed from the winner.
  - less, equal and ID are captured into the response register.
  - `last_gnt` is updated to the winner.
  - The winner's counter increments, saturating at all-ones.
- When no requester is valid, the `brc` inputs select requester 0. The response register does not change, and `last_gnt` does not change.
- The response register holds `o_rsp_*` stable while `o_rsp_valid` & !`i_rsp_ready`.
- Requesters must hold operands stable while valid and not ready. The block does not check this.

## Timing
- Reset values:
  - `o_rsp_valid`, `o_rsp_id`, `o_rsp_less`, `o_rsp_equal` = 0.
  - Both counters = 0.
  - `last_gnt` = 1, so requester 0 wins the first tie.
- Latency: accept in cycle N gives `o_rsp_valid`=1 with the result in cycle N+1.
- Throughput: one compare per cycle while `i_rsp_ready` is held high.
- Backpressure: FULL with `i_rsp_ready`=0 forces both readies to 0 in that same cycle.
- Simultaneous consume and accept: the new result replaces the old one at the edge with no bubble.
- Counter saturation: at all-ones a further accept leaves the count unchanged. The other counter is unaffected.
- Reset asserted mid-operation: all state clears immediately (asynchronous), and any pending response is dropped. Readies are valid-dependent again from the first cycle after deassertion.

## Structure
- Package `brc_arb_pkg` holds:
  - `typedef enum logic {REQ_BR=1'b0, REQ_SLT=1'b1} req_id_e`, used for `o_rsp_id` and `last_gnt`.
  - `typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_e`.
- Exactly one `brc` is instantiated inside (`u_brc`). No comparator logic is duplicated.
- Round-robin winner selection stays inline. No separate sub-module is needed for two requesters.

## Test plan
- Reset, then req0 only, rs1=5, rs2=7, signed=0: ready0=1 in the same cycle. Next cycle rsp_valid=1, id=0, less=1, equal=0, cnt0=1.
- Both valid every cycle, `i_rsp_ready`=1, `FIXED_PRIO`=0: grants alternate 0,1,0,1. After 8 cycles cnt0=4 and cnt1=4.
- Signed vs unsigned, rs1=0xFFFF_FFFF, rs2=1:
  - signed=1 → less=1.
  - signed=0 → less=0.
  - rs1=rs2=0x8000_0000 → equal=1, less=0.
- Response stall: fill the response register, hold `i_rsp_ready`=0 for 3 cycles with both requesters valid. Both readies stay 0 and the `o_rsp_*` values are unchanged. Releasing `i_rsp_ready` gives an accept in the same cycle.
- `FIXED_PRIO`=1 with both requesters valid for 5 cycles: only requester 0 is granted. Counter saturation with `CNT_W`=2: the fourth and later accepts hold cnt0 at 3.
- Assert `i_rst_n` low mid-stream while FULL: all outputs go to 0 at once, without waiting for a clock edge. After release, the first tie goes to requester 0.

Source files
------------

// File: rtl/brc_arb_pkg.sv
// brc_arb_pkg: shared requester id and response-state types for brc_arb
package brc_arb_pkg;
  typedef enum logic {REQ_BR = 1'b0, REQ_SLT = 1'b1} req_id_e;
  typedef enum logic {RSP_EMPTY, RSP_FULL} rsp_state_e;
endpackage

// File: rtl/brc.sv
// brc: 32-bit comparator, i_br_un=1 selects a signed less-than
module brc (
  input  logic [31:0] i_br_data1,
  input  logic [31:0] i_br_data2,
  input  logic        i_br_un,
  output logic        o_br_less,
  output logic        o_br_equal
);
  always_comb begin
    o_br_equal = i_br_data1 == i_br_data2;
    o_br_less  = i_br_un ? ($signed(i_br_data1) < $signed(i_br_data2)) : (i_br_data1 < i_br_data2);
  end
endmodule

// File: rtl/brc_arb.sv
// brc_arb: round-robin/fixed arbiter sharing one brc between branch and slt requesters with a registered tagged response
module brc_arb
  import brc_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [31:0]      i_req0_rs1,
  input  logic [31:0]      i_req0_rs2,
  input  logic             i_req0_signed,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [31:0]      i_req1_rs1,
  input  logic [31:0]      i_req1_rs2,
  input  logic             i_req1_signed,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic             o_rsp_less,
  output logic             o_rsp_equal,
  output logic [CNT_W-1:0] o_gnt_cnt0,
  output logic [CNT_W-1:0] o_gnt_cnt1
);
  rsp_state_e  state;
  req_id_e     last_gnt, win, rsp_id;
  logic        can_take, acc, less, equal, br_un;
  logic [31:0] rs1, rs2;
  always_comb begin
    win = (i_req0_valid & i_req1_valid) ? (FIXED_PRIO ? REQ_BR : (last_gnt == REQ_BR ? REQ_SLT : REQ_BR))
                                         : (i_req1_valid ? REQ_SLT : REQ_BR);
    can_take     = (state == RSP_EMPTY) | i_rsp_ready;
    o_req0_ready = can_take & (win == REQ_BR);
    o_req1_ready = can_take & (win == REQ_SLT);
    acc          = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);
    rs1          = win == REQ_SLT ? i_req1_rs1 : i_req0_rs1;
    rs2          = win == REQ_SLT ? i_req1_rs2 : i_req0_rs2;
    br_un        = win == REQ_SLT ? i_req1_signed : i_req0_signed;
    o_rsp_valid  = state == RSP_FULL;
    o_rsp_id     = rsp_id;
  end
  brc u_brc (
    .i_br_data1 (rs1),
    .i_br_data2 (rs2),
    .i_br_un    (br_un),
    .o_br_less  (less),
    .o_br_equal (equal)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= RSP_EMPTY;
      last_gnt    <= REQ_SLT;
      rsp_id      <= REQ_BR;
      o_rsp_less  <= 1'b0;
      o_rsp_equal <= 1'b0;
      o_gnt_cnt0  <= '0;
      o_gnt_cnt1  <= '0;
    end else if (acc) begin
      state       <= RSP_FULL;
      rsp_id      <= win;
      last_gnt    <= win;
      o_rsp_less  <= less;
      o_rsp_equal <= equal;
      if (win == REQ_BR && !(&o_gnt_cnt0)) o_gnt_cnt0 <= o_gnt_cnt0 + CNT_W'(1);
      if (win == REQ_SLT && !(&o_gnt_cnt1)) o_gnt_cnt1 <= o_gnt_cnt1 + CNT_W'(1);
    end else if (i_rsp_ready) begin
      state <= RSP_EMPTY;
    end
  end
endmodule
